// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: byte-serial multi-precision adder driving a shared external 8-bit adder; define SEQ_SUB_EN for op_sub subtraction
module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] op_a,
  input  logic [8*WORDS-1:0] op_b,
  input  logic               cin,
`ifdef SEQ_SUB_EN
  input  logic               op_sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] sum,
  output logic               cout,
  output logic [7:0]         add_a,
  output logic [7:0]         add_b,
  output logic               add_cin,
  input  logic [7:0]         add_sum,
  input  logic               add_cout
);
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state;
  logic [8*WORDS-1:0] r_a, r_b;
  logic [IW-1:0]      r_idx;
  logic               r_cin, r_carry;
  logic               w_run, w_sub;
  logic [7:0]         w_b;
`ifdef SEQ_SUB_EN
  logic               r_sub;
  assign w_sub = r_sub;
`else
  assign w_sub = 1'b0;
`endif
  assign in_ready = r_state == IDLE;
  assign w_run    = r_state == RUN;
  assign w_b      = r_b[8*r_idx +: 8];
  assign add_a    = w_run ? r_a[8*r_idx +: 8] : 8'd0;
  assign add_b    = w_run ? (w_sub ? ~w_b : w_b) : 8'd0;
  assign add_cin  = w_run & (r_idx == '0 ? (w_sub | r_cin) : r_carry);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_cin     <= 1'b0;
      r_carry   <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SEQ_SUB_EN
      r_sub     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= op_a;
          r_b     <= op_b;
          r_cin   <= cin;
          r_idx   <= '0;
          r_state <= RUN;
`ifdef SEQ_SUB_EN
          r_sub   <= op_sub;
`endif
        end
        RUN: begin
          sum[8*r_idx +: 8] <= add_sum;
          r_carry           <= add_cout;
          if (r_idx == LAST) begin
            cout      <= add_cout;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else r_idx <= r_idx + 1'b1;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: randomized and directed checks of wide_add_sequencer against a plain-arithmetic model
module tb_wide_add_sequencer;
  localparam int W = 4;
  localparam int N = 8 * W;
  logic         clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 0, op_sub = 0;
  logic         in_ready, out_valid, cout, add_cin, add_cout;
  logic [N-1:0] op_a = '0, op_b = '0, sum;
  logic [7:0]   add_a, add_b, add_sum;
  int           errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);
  wide_add_sequencer #(.WORDS(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SEQ_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );
  function automatic logic [N:0] ref_op(input logic [N-1:0] a, b, input logic c, s);
    return s ? {1'b0, a} + {1'b0, ~b} + (N+1)'(1) : {1'b0, a} + {1'b0, b} + (N+1)'(c);
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_op(input logic [N-1:0] a, b, input logic c, s);
    chk("in_ready_idle", in_ready, 1);
    op_a = a; op_b = b; cin = c; op_sub = s; in_valid = 1;
    tick;
    in_valid = 0;
    op_a = $urandom; op_b = $urandom; cin = 1'($urandom); op_sub = 1'($urandom);
    chk("in_ready_busy", in_ready, 0);
  endtask
  task automatic wait_valid(output int lat, output logic [W-1:0] cins);
    lat = 0;
    cins = '0;
    while (!out_valid && lat < 64) begin
      if (lat < W) cins[lat] = add_cin;
      tick;
      lat++;
    end
    chk("latency", lat, W);
  endtask
  task automatic check_result(input logic [N-1:0] a, b, input logic c, s);
    logic [N:0] e;
    e = ref_op(a, b, c, s);
    chk("sum", sum, e[N-1:0]);
    chk("cout", cout, e[N]);
  endtask
  task automatic handshake;
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask
  initial begin
    int lat;
    logic [W-1:0] cins;
    logic [N-1:0] a, b;
    logic c, s;
    repeat (2) tick;
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    start_op(32'h2, 32'h5, 0, 0);
    wait_valid(lat, cins);
    check_result(32'h2, 32'h5, 0, 0);
    handshake;
    start_op(32'hFFFFFFFF, 32'h1, 0, 0);
    wait_valid(lat, cins);
    chk("carry_chain", cins, 4'b1110);
    check_result(32'hFFFFFFFF, 32'h1, 0, 0);
    handshake;
    start_op(32'h12345678, 32'h9ABCDEF0, 1, 0);
    wait_valid(lat, cins);
    check_result(32'h12345678, 32'h9ABCDEF0, 1, 0);
    op_a = 32'h11111111; op_b = 32'h22222222; cin = 0; op_sub = 0; in_valid = 1;
    repeat (5) begin
      tick;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      check_result(32'h12345678, 32'h9ABCDEF0, 1, 0);
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("bp_hs_in_ready", in_ready, 1);
    chk("bp_hs_valid", out_valid, 0);
    tick;
    in_valid = 0;
    chk("bp_accepted", in_ready, 0);
    wait_valid(lat, cins);
    check_result(32'h11111111, 32'h22222222, 0, 0);
    handshake;
    start_op(32'hDEADBEEF, 32'h01020304, 0, 0);
    tick;
    tick;
    rst = 1;
    tick;
    rst = 0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_add_cin", add_cin, 0);
    repeat (W + 2) begin
      tick;
      chk("mid_rst_no_pulse", out_valid, 0);
    end
    start_op(32'h80808080, 32'h80808080, 1, 0);
    wait_valid(lat, cins);
    chk("rst_follow_sum", sum, 32'h01010101);
    chk("rst_follow_cout", cout, 1);
    handshake;
`ifdef SEQ_SUB_EN
    start_op(32'h5, 32'h7, 0, 1);
    wait_valid(lat, cins);
    chk("sub_sum_neg", sum, 32'hFFFFFFFE);
    chk("sub_cout_neg", cout, 0);
    handshake;
    start_op(32'h7, 32'h5, 0, 1);
    wait_valid(lat, cins);
    chk("sub_sum_pos", sum, 32'h2);
    chk("sub_cout_pos", cout, 1);
    handshake;
`endif
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      c = 1'($urandom);
`ifdef SEQ_SUB_EN
      s = 1'($urandom);
`else
      s = 0;
`endif
      out_ready = 1'($urandom);
      start_op(a, b, c, s);
      wait_valid(lat, cins);
      check_result(a, b, c, s);
      handshake;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
